// File: rtl/vend_fsm_multi_if.sv
// Front-end (coin/selection/cancel/refill) and actuator (dispense/change/status)
// signal bundle of the multi-beverage vending controller.
interface vend_fsm_multi_if #(
   parameter int N_BEV = 4,
   parameter int CW    = 16
);
   localparam int IW = (N_BEV > 1) ? $clog2(N_BEV) : 1;

   logic [CW-1:0]    coin_in;
   logic             sel_valid;
   logic [IW-1:0]    sel_id;
   logic             cancel_in;
   logic             refill_in;
   logic [IW-1:0]    refill_id;
   logic [CW-1:0]    credit_out;
   logic             bev_valid;
   logic [IW-1:0]    bev_id;
   logic             change_valid;
   logic [CW-1:0]    change_out;
   logic             coin_reject;
   logic             sel_err;
   logic [N_BEV-1:0] sold_out;
   logic             busy;

   modport master (
      output coin_in, sel_valid, sel_id, cancel_in, refill_in, refill_id,
      input  credit_out, bev_valid, bev_id, change_valid, change_out,
             coin_reject, sel_err, sold_out, busy
   );

   modport slave (
      input  coin_in, sel_valid, sel_id, cancel_in, refill_in, refill_id,
      output credit_out, bev_valid, bev_id, change_valid, change_out,
             coin_reject, sel_err, sold_out, busy
   );
endinterface

// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller: coin credit, per-product price and stock,
// cancel/refund and cycle-counted dispense/change sequencing.
module vend_fsm_multi #(
   parameter int                   N_BEV       = 4,
   parameter int                   CW          = 16,
   parameter logic [N_BEV*CW-1:0]  PRICES      = {16'd100, 16'd70, 16'd50, 16'd30},
   parameter int                   STOCK_W     = 4,
   parameter int                   STOCK_INIT  = 8,
   parameter int                   STOCK_MAX   = 15,
   parameter int                   DISP_DLY    = 1,
   parameter int                   CHG_DLY     = 2,
   parameter int                   MAX_CREDIT  = 500,
   parameter int                   KEEP_CREDIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   vend_fsm_multi_if.slave bus
);
   localparam int IW = (N_BEV > 1) ? $clog2(N_BEV) : 1;
   localparam int DW = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_DISP = 3'd1,
      DISPENSE  = 3'd2,
      CHG_CHECK = 3'd3,
      WAIT_CHG  = 3'd4,
      CHANGE    = 3'd5
   } state_t;

   function automatic logic [CW-1:0] price_of(input logic [IW-1:0] idx);
      logic [CW-1:0] p;
      p = '0;
      for (int i = 0; i < N_BEV; i++) begin
         p = (idx == IW'(i)) ? PRICES[i*CW +: CW] : p;
      end
      return p;
   endfunction

   function automatic logic [CW-1:0] min_price();
      logic [CW-1:0] m;
      m = PRICES[CW-1:0];
      for (int i = 1; i < N_BEV; i++) begin
         m = (PRICES[i*CW +: CW] < m) ? PRICES[i*CW +: CW] : m;
      end
      return m;
   endfunction

   function automatic logic is_denom(input logic [CW-1:0] c);
      return (c == CW'(16'd10))  || (c == CW'(16'd20))  || (c == CW'(16'd50)) ||
             (c == CW'(16'd100)) || (c == CW'(16'd200));
   endfunction

   localparam logic [CW-1:0] MIN_PRICE = min_price();

   state_t             state_r, state_s;
   logic [DW-1:0]      cnt_r, cnt_s;
   logic [CW-1:0]      credit_r, credit_s;
   logic [IW-1:0]      id_r, id_s;
   logic [STOCK_W-1:0] stock_r [N_BEV];
   logic [STOCK_W-1:0] stock_s [N_BEV];
   logic               bev_valid_r, bev_valid_s;
   logic [IW-1:0]      bev_id_r, bev_id_s;
   logic               change_valid_r, change_valid_s;
   logic [CW-1:0]      change_out_r, change_out_s;
   logic               coin_reject_r, coin_reject_s;
   logic               sel_err_r, sel_err_s;
   logic [N_BEV-1:0]   sold_out_r, sold_out_s;
   logic               busy_r, busy_s;
   logic               dispense_s, coin_nz_s, coin_legal_s, sel_stock_s, sel_ok_s;
   logic               cancel_acc_s, sel_acc_s;
   logic [CW:0]        coin_sum_s;
   logic [N_BEV-1:0]   inc_s, dec_s;

   // Acceptance qualifiers for the inputs sampled in IDLE
   always_comb begin
      coin_nz_s    = (bus.coin_in != '0);
      coin_sum_s   = {1'b0, credit_r} + {1'b0, bus.coin_in};
      coin_legal_s = is_denom(bus.coin_in) && (coin_sum_s <= (CW+1)'(MAX_CREDIT));
      sel_stock_s  = 1'b0;
      for (int i = 0; i < N_BEV; i++) begin
         sel_stock_s = (bus.sel_id == IW'(i)) ? (stock_r[i] != '0) : sel_stock_s;
      end
      sel_ok_s     = (int'(bus.sel_id) < N_BEV) && (credit_r >= price_of(bus.sel_id)) && sel_stock_s;
      cancel_acc_s = bus.cancel_in && (credit_r != '0);
      sel_acc_s    = !cancel_acc_s && bus.sel_valid && sel_ok_s;
   end

   // Next-state and next-output logic of the sale sequencer
   always_comb begin
      state_s        = state_r;
      cnt_s          = cnt_r;
      credit_s       = credit_r;
      id_s           = id_r;
      bev_valid_s    = 1'b0;
      bev_id_s       = bev_id_r;
      change_valid_s = 1'b0;
      change_out_s   = '0;
      coin_reject_s  = coin_nz_s;
      sel_err_s      = 1'b0;
      dispense_s     = 1'b0;
      case (state_r)
         IDLE: begin
            sel_err_s = !cancel_acc_s && bus.sel_valid && !sel_ok_s;
            if (cancel_acc_s) begin
               state_s = WAIT_CHG;
               cnt_s   = '0;
            end else if (sel_acc_s) begin
               state_s = WAIT_DISP;
               cnt_s   = '0;
               id_s    = bus.sel_id;
            end else begin
               state_s = IDLE;
            end
            // A coin is only banked when no cancel or sale was taken this edge
            if (!cancel_acc_s && !sel_acc_s && coin_legal_s) begin
               credit_s      = coin_sum_s[CW-1:0];
               coin_reject_s = 1'b0;
            end else begin
               coin_reject_s = coin_nz_s;
            end
         end
         WAIT_DISP: begin
            if (cnt_r == DW'(DISP_DLY - 1)) begin
               state_s = DISPENSE;
            end else begin
               cnt_s = cnt_r + DW'(1'b1);
            end
         end
         DISPENSE: begin
            bev_valid_s = 1'b1;
            bev_id_s    = id_r;
            credit_s    = credit_r - price_of(id_r);
            dispense_s  = 1'b1;
            state_s     = CHG_CHECK;
         end
         CHG_CHECK: begin
            if (credit_r == '0) begin
               state_s = IDLE;
            end else if ((KEEP_CREDIT != 0) && (credit_r >= MIN_PRICE)) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_CHG;
               cnt_s   = '0;
            end
         end
         WAIT_CHG: begin
            if (cnt_r == DW'(CHG_DLY - 1)) begin
               state_s = CHANGE;
            end else begin
               cnt_s = cnt_r + DW'(1'b1);
            end
         end
         CHANGE: begin
            change_valid_s = 1'b1;
            change_out_s   = credit_r;
            credit_s       = '0;
            state_s        = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // Stock bookkeeping: a refill and a dispense of the same product cancel out
   always_comb begin
      for (int i = 0; i < N_BEV; i++) begin
         inc_s[i] = bus.refill_in && (bus.refill_id == IW'(i));
         dec_s[i] = dispense_s && (id_r == IW'(i));
         if (inc_s[i] && !dec_s[i]) begin
            stock_s[i] = (stock_r[i] >= STOCK_W'(STOCK_MAX)) ? stock_r[i] : stock_r[i] + STOCK_W'(1'b1);
         end else if (dec_s[i] && !inc_s[i]) begin
            stock_s[i] = stock_r[i] - STOCK_W'(1'b1);
         end else begin
            stock_s[i] = stock_r[i];
         end
         sold_out_s[i] = (stock_s[i] == '0);
      end
   end

   // State, stock and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         cnt_r          <= '0;
         credit_r       <= '0;
         id_r           <= '0;
         for (int i = 0; i < N_BEV; i++) stock_r[i] <= STOCK_W'(STOCK_INIT);
         bev_valid_r    <= 1'b0;
         bev_id_r       <= '0;
         change_valid_r <= 1'b0;
         change_out_r   <= '0;
         coin_reject_r  <= 1'b0;
         sel_err_r      <= 1'b0;
         sold_out_r     <= (STOCK_INIT == 0) ? {N_BEV{1'b1}} : {N_BEV{1'b0}};
         busy_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         credit_r       <= credit_s;
         id_r           <= id_s;
         for (int i = 0; i < N_BEV; i++) stock_r[i] <= stock_s[i];
         bev_valid_r    <= bev_valid_s;
         bev_id_r       <= bev_id_s;
         change_valid_r <= change_valid_s;
         change_out_r   <= change_out_s;
         coin_reject_r  <= coin_reject_s;
         sel_err_r      <= sel_err_s;
         sold_out_r     <= sold_out_s;
         busy_r         <= busy_s;
      end
   end

   assign bus.credit_out   = credit_r;
   assign bus.bev_valid    = bev_valid_r;
   assign bus.bev_id       = bev_id_r;
   assign bus.change_valid = change_valid_r;
   assign bus.change_out   = change_out_r;
   assign bus.coin_reject  = coin_reject_r;
   assign bus.sel_err      = sel_err_r;
   assign bus.sold_out     = sold_out_r;
   assign bus.busy         = busy_r;
endmodule

// File: tb/tb_vend_fsm_multi.sv
// Drives two vending controllers (keep-credit/stock 8 and refund/stock 1) with
// the same directed stimulus; checks every cycle against a timeline model.
module tb_vend_fsm_multi;
   localparam int NB = 4;
   localparam int CW = 16;
   localparam int IW = 2;
   localparam int D  = 1;
   localparam int C  = 2;
   localparam logic [NB*CW-1:0] PR = {16'd100, 16'd70, 16'd50, 16'd30};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] coin = '0;
   logic          selv = 1'b0;
   logic [IW-1:0] selid = '0;
   logic          cancel = 1'b0;
   logic          refill = 1'b0;
   logic [IW-1:0] refid = '0;

   always #5 clk = ~clk;

   vend_fsm_multi_if #(.N_BEV(NB), .CW(CW)) ifa ();
   vend_fsm_multi_if #(.N_BEV(NB), .CW(CW)) ifb ();

   assign ifa.coin_in = coin;    assign ifb.coin_in = coin;
   assign ifa.sel_valid = selv;  assign ifb.sel_valid = selv;
   assign ifa.sel_id = selid;    assign ifb.sel_id = selid;
   assign ifa.cancel_in = cancel; assign ifb.cancel_in = cancel;
   assign ifa.refill_in = refill; assign ifb.refill_in = refill;
   assign ifa.refill_id = refid; assign ifb.refill_id = refid;

   vend_fsm_multi #(.N_BEV(NB), .CW(CW), .PRICES(PR), .STOCK_W(4), .STOCK_INIT(8),
      .STOCK_MAX(15), .DISP_DLY(D), .CHG_DLY(C), .MAX_CREDIT(500), .KEEP_CREDIT(1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));

   vend_fsm_multi #(.N_BEV(NB), .CW(CW), .PRICES(PR), .STOCK_W(4), .STOCK_INIT(1),
      .STOCK_MAX(15), .DISP_DLY(D), .CHG_DLY(C), .MAX_CREDIT(500), .KEEP_CREDIT(0))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   int price [4] = '{30, 50, 70, 100};
   int keep  [2] = '{1, 0};
   int sinit [2] = '{8, 1};

   // model state: credit, stock and the edges at which scheduled events fire
   int m_credit [2];
   int m_stock  [2][4];
   int idle_from [2];
   int disp_at [2];
   int disp_id [2];
   int chg_at  [2];
   int e_credit [2], e_bv [2], e_bid [2], e_cv [2], e_co [2];
   int e_rej [2], e_serr [2], e_sold [2], e_busy [2];
   int g_credit [2], g_bv [2], g_bid [2], g_cv [2], g_co [2];
   int g_rej [2], g_serr [2], g_sold [2], g_busy [2];
   int n = 0;
   int checks = 0;
   int errors = 0;

   task automatic model_edge(input int k);
      int  d, cv;
      bit  disp, cacc, sacc, legal;
      if (rst) begin
         m_credit[k] = 0;
         for (int i = 0; i < 4; i++) m_stock[k][i] = sinit[k];
         idle_from[k] = -1; disp_at[k] = -1; chg_at[k] = -1;
         e_bv[k] = 0; e_bid[k] = 0; e_cv[k] = 0; e_co[k] = 0; e_rej[k] = 0; e_serr[k] = 0;
      end else begin
         e_bv[k] = 0; e_cv[k] = 0; e_co[k] = 0; e_rej[k] = 0; e_serr[k] = 0;
         disp = 0; d = 0; cv = int'(coin);
         if (n == disp_at[k]) begin
            disp = 1; d = disp_id[k]; disp_at[k] = -1;
            e_bv[k] = 1; e_bid[k] = d;
            m_credit[k] -= price[d];
            if (m_credit[k] == 0 || (keep[k] == 1 && m_credit[k] >= 30)) begin
               idle_from[k] = n + 1;
            end else begin
               chg_at[k] = n + C + 2;
               idle_from[k] = chg_at[k];
            end
         end else if (n == chg_at[k]) begin
            e_cv[k] = 1; e_co[k] = m_credit[k];
            m_credit[k] = 0; chg_at[k] = -1;
         end
         if (n > idle_from[k]) begin
            cacc = cancel && m_credit[k] > 0;
            sacc = 0;
            legal = (cv == 10 || cv == 20 || cv == 50 || cv == 100 || cv == 200) &&
                    (m_credit[k] + cv <= 500);
            if (cacc) begin
               chg_at[k] = n + C + 1;
               idle_from[k] = chg_at[k];
            end else if (selv) begin
               if (m_credit[k] >= price[selid] && m_stock[k][selid] > 0) begin
                  sacc = 1; disp_at[k] = n + D + 1; disp_id[k] = int'(selid);
                  idle_from[k] = 32'h3fff_ffff;
               end else begin
                  e_serr[k] = 1;
               end
            end
            if (!cacc && !sacc && legal) m_credit[k] += cv;
            else if (cv != 0) e_rej[k] = 1;
         end else if (cv != 0) begin
            e_rej[k] = 1;
         end
         if (disp && !(refill && int'(refid) == d)) m_stock[k][d] -= 1;
         if (refill && !(disp && int'(refid) == d) && m_stock[k][refid] < 15)
            m_stock[k][refid] += 1;
      end
      e_credit[k] = m_credit[k];
      e_sold[k] = 0;
      for (int i = 0; i < 4; i++) if (m_stock[k][i] == 0) e_sold[k] += (1 << i);
      e_busy[k] = (n >= idle_from[k]) ? 0 : 1;
   endtask

   task automatic chk(input string nm, input int k, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, k, n, got, exp);
      end
   endtask

   task automatic lit(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, n, got, exp);
      end
   endtask

   task automatic compare_all();
      g_credit[0] = int'(ifa.credit_out); g_credit[1] = int'(ifb.credit_out);
      g_bv[0] = int'(ifa.bev_valid);      g_bv[1] = int'(ifb.bev_valid);
      g_bid[0] = int'(ifa.bev_id);        g_bid[1] = int'(ifb.bev_id);
      g_cv[0] = int'(ifa.change_valid);   g_cv[1] = int'(ifb.change_valid);
      g_co[0] = int'(ifa.change_out);     g_co[1] = int'(ifb.change_out);
      g_rej[0] = int'(ifa.coin_reject);   g_rej[1] = int'(ifb.coin_reject);
      g_serr[0] = int'(ifa.sel_err);      g_serr[1] = int'(ifb.sel_err);
      g_sold[0] = int'(ifa.sold_out);     g_sold[1] = int'(ifb.sold_out);
      g_busy[0] = int'(ifa.busy);         g_busy[1] = int'(ifb.busy);
      for (int k = 0; k < 2; k++) begin
         chk("credit_out", k, g_credit[k], e_credit[k]);
         chk("bev_valid", k, g_bv[k], e_bv[k]);
         chk("bev_id", k, g_bid[k], e_bid[k]);
         chk("change_valid", k, g_cv[k], e_cv[k]);
         chk("change_out", k, g_co[k], e_co[k]);
         chk("coin_reject", k, g_rej[k], e_rej[k]);
         chk("sel_err", k, g_serr[k], e_serr[k]);
         chk("sold_out", k, g_sold[k], e_sold[k]);
         chk("busy", k, g_busy[k], e_busy[k]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      n++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic put_coin(input int v);
      coin = CW'(v); step(); coin = '0;
   endtask

   task automatic sel(input int id);
      selv = 1'b1; selid = IW'(id); step(); selv = 1'b0;
   endtask

   task automatic cxl();
      cancel = 1'b1; step(); cancel = 1'b0;
   endtask

   task automatic rfl(input int id);
      refill = 1'b1; refid = IW'(id); step(); refill = 1'b0;
   endtask

   task automatic idle(input int cyc);
      repeat (cyc) step();
   endtask

   initial begin
      // reset
      step();
      rst = 1'b0;
      lit("reset_credit_a", int'(ifa.credit_out), 0);
      lit("reset_busy_a", int'(ifa.busy), 0);
      lit("reset_sold_b", int'(ifb.sold_out), 0);
      idle(2);

      // 20+10, buy product 0 with exact credit
      put_coin(20); put_coin(10);
      lit("credit_30_a", int'(ifa.credit_out), 30);
      sel(0); step(); step();
      lit("bev_valid_a", int'(ifa.bev_valid), 1);
      lit("bev_id_a", int'(ifa.bev_id), 0);
      lit("credit_after_buy_a", int'(ifa.credit_out), 0);
      idle(6);
      lit("sold0_b", int'(ifb.sold_out), 1);

      // 200 then product 3: a keeps 100, b refunds 100 at E+6
      put_coin(200);
      sel(3); idle(6);
      lit("change_valid_b", int'(ifb.change_valid), 1);
      lit("change_out_b", int'(ifb.change_out), 100);
      lit("kept_credit_a", int'(ifa.credit_out), 100);
      idle(3);
      lit("sold03_b", int'(ifb.sold_out), 9);

      // cancel refunds the kept credit at E+3
      cxl(); idle(3);
      lit("cancel_change_a", int'(ifa.change_out), 100);
      idle(2);

      // insufficient credit, then cancel
      put_coin(20);
      sel(0);
      lit("sel_err_a", int'(ifa.sel_err), 1);
      lit("credit_kept_a", int'(ifa.credit_out), 20);
      cxl(); idle(3);
      lit("refund_20_a", int'(ifa.change_out), 20);
      lit("refund_credit_a", int'(ifa.credit_out), 0);
      step();
      lit("busy_low_a", int'(ifa.busy), 0);

      // credit cap, illegal denominations, coin while busy
      put_coin(200); put_coin(200); put_coin(100);
      put_coin(10);
      lit("cap_reject_a", int'(ifa.coin_reject), 1);
      lit("cap_credit_a", int'(ifa.credit_out), 500);
      put_coin(5);
      put_coin(30);
      lit("coin30_reject_a", int'(ifa.coin_reject), 1);
      sel(1);
      put_coin(10);
      lit("busy_coin_reject_a", int'(ifa.coin_reject), 1);
      idle(8);
      lit("after_sel1_credit_a", int'(ifa.credit_out), 450);
      lit("after_sel1_credit_b", int'(ifb.credit_out), 0);
      lit("sold013_b", int'(ifb.sold_out), 11);
      cxl(); idle(5);

      // refill on the dispense edge of the same product
      put_coin(50); put_coin(20);
      sel(2); step();
      rfl(2);
      lit("refill_on_dispense_b", int'(ifb.sold_out), 11);
      idle(4);
      put_coin(50); put_coin(20);
      sel(2); idle(6);
      lit("sold_all_b", int'(ifb.sold_out), 15);
      put_coin(50); put_coin(20);
      sel(2);
      lit("soldout_sel_err_b", int'(ifb.sel_err), 1);
      lit("instock_no_err_a", int'(ifa.sel_err), 0);
      idle(6);
      cxl(); idle(5);

      // 16 refills saturate at 15: exactly 15 more sales of product 0
      for (int i = 0; i < 16; i++) rfl(0);
      for (int i = 0; i < 15; i++) begin
         put_coin(20); put_coin(10);
         sel(0); idle(4);
      end
      lit("sat_sold_a", int'(ifa.sold_out), 1);
      lit("sat_sold_b", int'(ifb.sold_out), 15);
      put_coin(20); put_coin(10);
      sel(0);
      lit("sat_sel_err_a", int'(ifa.sel_err), 1);
      lit("sat_sel_err_b", int'(ifb.sel_err), 1);
      cxl(); idle(5);

      // reset while waiting to pay change
      put_coin(50);
      cxl(); step();
      rst = 1'b1; step(); rst = 1'b0;
      lit("rst_credit_a", int'(ifa.credit_out), 0);
      lit("rst_busy_a", int'(ifa.busy), 0);
      lit("rst_change_valid_b", int'(ifb.change_valid), 0);
      lit("rst_stock_b", int'(ifb.sold_out), 0);
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vend_fsm_multi.md
# vend_fsm_multi

Parametrised multi-beverage vending controller, the next generation of the single-FSM water/soda vendor. Accumulates validated coin credit, sells one of `N_BEV` products at per-product prices with per-product stock tracking, and supports cancel/refund, a credit cap and a configurable change policy. Dispense and change delays are cycle-counted, not delay-based. Sits between the coin/button front-end and the dispenser/change-hopper actuators.

## Interface
- `N_BEV`, 4: number of products, 2..8.
- `CW`, 16: credit/coin/change width.
- `PRICES`, {16'd100,16'd70,16'd50,16'd30}: packed `N_BEV*CW`; price of product i at bits [i*CW +: CW].
- `STOCK_W`, 4: stock counter width; `STOCK_INIT`, 8: stock after reset; `STOCK_MAX`, 15: refill saturation.
- `DISP_DLY`, 1: cycles in WAIT_DISP, ≥1.
- `CHG_DLY`, 2: cycles in WAIT_CHG, ≥1.
- `MAX_CREDIT`, 500: credit cap.
- `KEEP_CREDIT`, 1: 1 = keep leftover credit ≥ min(PRICES); 0 = always refund leftover.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `coin_in` in CW: inserted coin value; 0 = no coin.
- `sel_valid` in 1: selection strobe; `sel_id` in $clog2(N_BEV): product index.
- `cancel_in` in 1: refund request.
- `refill_in` in 1: add one unit; `refill_id` in $clog2(N_BEV): product index.
- `credit_out` out CW: current credit.
- `bev_valid` out 1: one-cycle dispense pulse; `bev_id` out $clog2(N_BEV): dispensed product.
- `change_valid` out 1: one-cycle change pulse; `change_out` out CW: change amount, 0 when not valid.
- `coin_reject` out 1: one-cycle pulse, coin returned. `sel_err` out 1: one-cycle pulse, selection refused.
- `sold_out` out N_BEV: bit i = stock[i]==0. `busy` out 1: state != IDLE.

## Operation
- Reset: one clock, synchronous, active-high. State IDLE. credit 0. All stock STOCK_INIT. All pulses 0. bev_id 0. change_out 0. sold_out 0 (if STOCK_INIT>0). Reset wins over every input, including mid-sale. Credit is lost on reset.
- States: IDLE, WAIT_DISP, DISPENSE, CHG_CHECK, WAIT_CHG, CHANGE.
- IDLE input priority, sampled each edge: cancel > selection > coin.
  - Cancel with credit>0: go to WAIT_CHG. Cancel with credit 0: ignored.
  - Selection accepted only if sel_id<N_BEV, credit ≥ PRICES[sel_id] and stock[sel_id]>0. Accepted: latch id, go to WAIT_DISP. Refused: sel_err pulses, stay in IDLE, credit unchanged.
  - Coin accepted only if it is one of {10,20,50,100,200} and credit+coin ≤ MAX_CREDIT. Accepted: credit += coin. Any other nonzero coin: coin_reject pulses.
  - A coin presented in the same cycle as an accepted cancel or selection is rejected (coin_reject pulses).
- WAIT_DISP: hold DISP_DLY cycles, then go to DISPENSE.
- DISPENSE (one cycle), registered at exit edge: bev_valid=1, bev_id=id, credit −= price, stock[id] −= 1. Next state CHG_CHECK.
- CHG_CHECK (one cycle):
  - credit==0: go to IDLE.
  - KEEP_CREDIT=1 and credit ≥ min(PRICES): go to IDLE, credit retained.
  - Otherwise: go to WAIT_CHG.
- WAIT_CHG: hold CHG_DLY cycles, then go to CHANGE.
- CHANGE (one cycle): change_valid=1, change_out=credit, credit cleared on the same edge. Next state IDLE.
- Outside IDLE: sel_valid and cancel_in are ignored without sel_err. Nonzero coins are rejected.
- Refill is accepted in any state: stock[refill_id] += 1, saturating at STOCK_MAX. A refill and a DISPENSE decrement on the same id in the same edge leave stock unchanged. refill_id ≥ N_BEV is ignored.
- Arithmetic is unsigned CW-bit. Overflow cannot occur because of the cap check.

## Timing
- All outputs are registered. credit_out, sold_out and busy reflect state after each edge.
- Selection accepted at edge E:
  - bev_valid high in cycle after edge E+DISP_DLY+1.
  - change_valid, if any, high after edge E+DISP_DLY+3+CHG_DLY.
- Cancel accepted at edge E: change_valid high after edge E+CHG_DLY+1.
- Coin accepted at edge E: credit_out updated after edge E. Back-to-back coins are accepted every cycle.
- coin_reject and sel_err are high for exactly the cycle after the offending sampling edge.

## Test plan
- Reset, then coins 20,10, select id 0 (price 30) → bev_valid with bev_id=0 two cycles after the select edge; credit 0; no change_valid; stock[0]=7.
- KEEP_CREDIT=1: credit 200, select id 3 (100) → credit 100 retained, no change. KEEP_CREDIT=0, same stimulus → change_valid with change_out=100 at E+6.
- Credit 20, select id 0 → sel_err pulse, credit 20. Then cancel → change_out=20 at E+3, credit 0, busy low afterwards.
- Insert 200,200,100 then 10 → 10 rejected (cap 500). Coins 5 and 30 rejected. Coin during WAIT_DISP rejected.
- STOCK_INIT=1: buy id 2 → sold_out[2]=1, next select id 2 → sel_err. Refill id 2 during DISPENSE of id 2 → stock unchanged. 16 refills saturate at 15.
- Assert rst in WAIT_CHG → next cycle IDLE, credit 0, no change_valid, stock restored to STOCK_INIT.
